// File: rtl/bus_pkg.sv
// Shared bus definitions for the core's pipelined responder interfaces.
package bus_pkg;

  localparam int BUS_DATA_WIDTH = 32;
  localparam int BUS_BE_WIDTH   = 4;

  typedef struct packed {
    logic [31:0]               address;
    logic                      read_enable;
    logic                      write_enable;
    logic [BUS_BE_WIDTH-1:0]   byte_enable;
    logic [BUS_DATA_WIDTH-1:0] write_data;
  } bus_req_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } wait_state_e;

endpackage

// File: rtl/pl_bus_ram_array.sv
// Single-port word RAM with per-byte write lanes and registered read.
module pl_bus_ram_array
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter     INIT_FILE  = ""
) (
  input  logic                      clock,
  input  logic [ADDR_WIDTH-1:0]     addr,
  input  logic [BUS_BE_WIDTH-1:0]   wr_lanes,
  input  logic [BUS_DATA_WIDTH-1:0] wr_data,
  input  logic                      rd_en,
  output logic [BUS_DATA_WIDTH-1:0] rd_data
);

  logic [BUS_DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [BUS_DATA_WIDTH-1:0] rd_data_q;

  // NOTE: the array and its read register have no reset, so contents survive reset and the
  // storage maps onto block RAM; every consumer masks rd_data with its own reset valid bit.
  always_ff @(posedge clock) begin
    for (int i = 0; i < BUS_BE_WIDTH; i++) begin
      if (wr_lanes[i]) mem[addr][8*i +: 8] <= wr_data[8*i +: 8];
    end
    if (rd_en) rd_data_q <= mem[addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/pl_bus_memory_responder.sv
// Bus responder: wait-state FSM in front of a word RAM, reads returned through a fixed-latency pipe.
module pl_bus_memory_responder
  import bus_pkg::*;
#(
  parameter int          ADDR_WIDTH   = 12,
  parameter logic [31:0] BASE_ADDR    = 32'h0,
  parameter int          READ_LATENCY = 1,
  parameter int          WAIT_CYCLES  = 0,
  parameter              INIT_FILE    = ""
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read_enable,
  input  logic        write_enable,
  input  logic [3:0]  byte_enable,
  input  logic [31:0] write_data,
  output logic        wait_req,
  output logic [31:0] read_data,
  output logic        valid
);

  bus_req_t    req;
  wait_state_e state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic        request, accept, rd_fire, in_range;
  logic [31:0] offset;
  logic [3:0]  wr_lanes;
  logic [31:0] ram_rdata, s0_data, out_data;
  logic        zero_q, zero_d;
  logic [READ_LATENCY-1:0] vld_q, vld_d;

  assign req = '{address: address, read_enable: read_enable, write_enable: write_enable,
                 byte_enable: byte_enable, write_data: write_data};
  assign request = req.read_enable | req.write_enable;

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    wait_req = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (request && WAIT_CYCLES != 0) begin
          state_d  = ST_WAIT;
          wcnt_d   = 4'(WAIT_CYCLES - 1);
          wait_req = 1'b1;
        end
      end
      ST_WAIT: begin
        if (!request) begin
          state_d = ST_IDLE;
          wcnt_d  = '0;
        end else if (wcnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          wait_req = 1'b1;
          wcnt_d   = wcnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign accept   = request & ~wait_req;
  assign offset   = req.address - BASE_ADDR;
  assign in_range = (offset[31:ADDR_WIDTH+2] == '0);
  // A simultaneous read+write is treated as a write only.
  assign rd_fire  = accept & req.read_enable & ~req.write_enable;
  assign wr_lanes = (accept && req.write_enable && in_range) ? req.byte_enable : 4'b0000;

  pl_bus_ram_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_FILE  (INIT_FILE)
  ) u_ram (
    .clock    (clock),
    .addr     (offset[ADDR_WIDTH+1:2]),
    .wr_lanes (wr_lanes),
    .wr_data  (req.write_data),
    .rd_en    (rd_fire & in_range),
    .rd_data  (ram_rdata)
  );

  always_comb begin
    vld_d    = vld_q << 1;
    vld_d[0] = rd_fire;
    zero_d   = rd_fire ? ~in_range : zero_q;
  end

  assign s0_data = zero_q ? 32'h0 : ram_rdata;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
      vld_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      vld_q   <= vld_d;
      zero_q  <= zero_d;
    end
  end

  // The RAM read register is stage 1; further stages carry data alongside vld_q.
  if (READ_LATENCY > 1) begin : g_pipe
    logic [31:0] dat_q [1:READ_LATENCY-1];
    logic [31:0] dat_d [1:READ_LATENCY-1];

    always_comb begin
      dat_d[1] = s0_data;
      for (int i = 2; i < READ_LATENCY; i++) dat_d[i] = dat_q[i-1];
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        for (int i = 1; i < READ_LATENCY; i++) dat_q[i] <= '0;
      end else begin
        for (int i = 1; i < READ_LATENCY; i++) dat_q[i] <= dat_d[i];
      end
    end

    assign out_data = dat_q[READ_LATENCY-1];
  end else begin : g_direct
    assign out_data = s0_data;
  end

  assign valid     = vld_q[READ_LATENCY-1];
  assign read_data = valid ? out_data : 32'h0;

endmodule
